// File: rtl/backend_types.sv
// Shared backend types. iqueue_t is the instruction-queue entry pushed by the fetch stage.
package backend_types;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } iqueue_t;

endpackage

// File: rtl/frontend_types.sv
// Front-end types: fetch FSM states, memory read strobes and small PC helpers.
package frontend_types;

  typedef enum logic [1:0] {FETCH, WAIT, HOLD, DISCARD} fetch_state_t;

  localparam logic [3:0] IMEM_RMASK_WORD = 4'hF;
  localparam logic [3:0] IMEM_RMASK_NONE = 4'h0;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding register for a fetched instruction the queue could not accept.
module fetch_skid
  import backend_types::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_load,
  input  logic    i_clear,
  input  iqueue_t i_data,
  output iqueue_t o_data,
  output logic    o_valid
);

  iqueue_t r_data;
  logic    r_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Sequential-PC fetch stage feeding the instruction queue, with redirect and back-pressure handling.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit
  import frontend_types::*;
  import backend_types::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h6000_0000,
  parameter logic [31:0] PC_STRIDE = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        iq_full,
  output logic        iq_wen,
  output iqueue_t     iq_wdata
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_discard
`endif
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_inc;
  logic [31:0]  w_redir_pc;
  logic         w_req;
  logic [31:0]  w_req_addr;
  logic         w_wen;
  iqueue_t      w_wdata;
  logic         w_skid_load;
  logic         w_skid_clear;
  iqueue_t      w_skid_in;
  iqueue_t      w_skid_data;
  logic         w_skid_valid;

  assign w_pc_inc   = r_pc + PC_STRIDE;
  assign w_redir_pc = word_align(redirect_pc);
  assign w_skid_in  = '{pc: r_pc, inst: imem_rdata};

  // Redirect outranks every other event, so it gates all requests and writes.
  always_comb begin
    w_req        = 1'b0;
    w_req_addr   = r_pc;
    w_wen        = 1'b0;
    w_wdata      = '0;
    w_skid_load  = 1'b0;
    w_skid_clear = 1'b0;
    if (rst && !redirect_valid) begin
      case (r_state)
        FETCH: w_req = 1'b1;
        WAIT: begin
          if (imem_resp && !iq_full) begin
            w_wen      = 1'b1;
            w_wdata    = w_skid_in;
            w_req      = 1'b1;
            w_req_addr = w_pc_inc;
          end else if (imem_resp) begin
            w_skid_load = 1'b1;
          end
        end
        HOLD: begin
          if (!iq_full) begin
            w_wen        = w_skid_valid;
            w_wdata      = w_skid_data;
            w_skid_clear = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (redirect_valid && r_state == HOLD) begin
      w_skid_clear = 1'b1;
    end
  end

  assign imem_rmask = w_req ? IMEM_RMASK_WORD : IMEM_RMASK_NONE;
  assign imem_addr  = w_req ? word_align(w_req_addr) : 32'd0;
  assign iq_wen     = w_wen;
  assign iq_wdata   = w_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= FETCH;
      r_pc    <= RESET_VEC;
    end else if (redirect_valid) begin
      r_pc <= w_redir_pc;
      case (r_state)
        WAIT, DISCARD: r_state <= imem_resp ? FETCH : DISCARD;
        default:       r_state <= FETCH;
      endcase
    end else begin
      case (r_state)
        FETCH: r_state <= WAIT;
        WAIT: begin
          if (imem_resp && !iq_full) r_pc <= w_pc_inc;
          else if (imem_resp)        r_state <= HOLD;
        end
        HOLD: begin
          if (!iq_full) begin
            r_pc    <= w_pc_inc;
            r_state <= FETCH;
          end
        end
        DISCARD: if (imem_resp) r_state <= FETCH;
        default: r_state <= FETCH;
      endcase
    end
  end

  fetch_skid u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  (w_skid_in),
    .o_data  (w_skid_data),
    .o_valid (w_skid_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_discard;
  logic        w_drop;

  // A response is lost if it lands during DISCARD or together with a redirect in WAIT.
  assign w_drop = imem_resp && ((r_state == DISCARD) || (r_state == WAIT && redirect_valid));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
      r_perf_discard <= '0;
    end else begin
      r_perf_fetched <= sat_inc(r_perf_fetched, w_wen);
      r_perf_stall   <= sat_inc(r_perf_stall, r_state == HOLD);
      r_perf_discard <= sat_inc(r_perf_discard, w_drop);
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
  assign perf_discard = r_perf_discard;
`endif

endmodule
